// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared GA datapath types, rate constants and crossover mask helper
package ga_pkg;

  typedef logic signed [7:0] chrom_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // 9 bits so a rate of 256 can mean "always"
  localparam logic [8:0]  CROSS_RATE_DEF = 9'd204;
  localparam logic [8:0]  MUT_RATE_DEF   = 9'd13;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [7:0] xover_mask(input logic [2:0] k);
    return (8'd1 << k) - 8'd1;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - free-running 32-bit Galois LFSR, reloaded with seed on reset
module lfsr_rng
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  output logic [31:0] rnd
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd <= seed;
    end else begin
      rnd <= (rnd >> 1) ^ (rnd[0] ? LFSR_TAPS : 32'h0);
    end
  end

endmodule

// File: rtl/crossover.sv
// rtl/crossover.sv - single-point crossover stage with 2-entry child-pair output buffer
module crossover
  import ga_pkg::*;
#(
  parameter logic [31:0] SEED       = 32'h5EED_C0DE,
  parameter logic [8:0]  CROSS_RATE = CROSS_RATE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  chrom_t      parent1,
  input  chrom_t      parent2,
  input  logic        force_en,
  input  logic [2:0]  force_cut,
  output logic        out_valid,
  input  logic        out_ready,
  output chrom_t      child1,
  output chrom_t      child2,
  output logic [15:0] xover_count
);

  function automatic logic [15:0] cross_pair(input chrom_t a, input chrom_t b,
                                             input logic [7:0] m);
    logic [7:0] ca;
    logic [7:0] cb;
    ca = (a & ~m) | (b & m);
    cb = (b & ~m) | (a & m);
    return {ca, cb};
  endfunction

  logic [31:0] rnd;
  logic        unused_rnd;
  logic        hit;
  logic [2:0]  cut;
  logic [2:0]  k;
  logic [15:0] pair;
  logic        accept;
  logic        pop;
  occ_t        occ;
  logic        head;
  logic        tail;
  logic [15:0] mem [2];

  lfsr_rng u_rng (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .rnd   (rnd)
  );

  assign unused_rnd = ^rnd[31:11];

  always_comb begin
    hit  = force_en | ({1'b0, rnd[7:0]} < CROSS_RATE);
    cut  = force_en ? force_cut : rnd[10:8];
    k    = hit ? cut : 3'd0;
    pair = cross_pair(parent1, parent2, xover_mask(k));
  end

  // Ready comes only from registered occupancy (plus reset), never from out_ready
  assign in_ready  = !reset && (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign child1    = mem[head][15:8];
  assign child2    = mem[head][7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      occ         <= OCC_EMPTY;
      head        <= 1'b0;
      tail        <= 1'b0;
      mem[0]      <= 16'h0;
      mem[1]      <= 16'h0;
      xover_count <= 16'h0;
    end else begin
      if (accept) begin
        mem[tail] <= pair;
        tail      <= ~tail;
        if (k != 3'd0 && xover_count != 16'hFFFF) begin
          xover_count <= xover_count + 16'd1;
        end
      end
      if (pop) begin
        head <= ~head;
      end
      case (occ)
        OCC_EMPTY: if (accept) occ <= OCC_ONE;
        OCC_ONE: begin
          if (accept && !pop)      occ <= OCC_FULL;
          else if (pop && !accept) occ <= OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ <= OCC_ONE;
        default:   occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_crossover.sv
// tb/tb_crossover.sv - directed self-checking bench for the crossover stage
module tb_crossover;

  localparam logic [31:0] SEED = 32'h5EED_C0DE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  parent1 = 8'h00;
  logic [7:0]  parent2 = 8'h00;
  logic        force_en = 1'b0;
  logic [2:0]  force_cut = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  child1;
  logic [7:0]  child2;
  logic [15:0] xover_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_lfsr;
  logic [15:0] exp_count;
  logic [7:0]  prev1;
  logic [7:0]  prev2;

  always #5 clk = ~clk;

  crossover #(.SEED(SEED), .CROSS_RATE(9'd204)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .parent1     (parent1),
    .parent2     (parent2),
    .force_en    (force_en),
    .force_cut   (force_cut),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .child1      (child1),
    .child2      (child2),
    .xover_count (xover_count)
  );

  // Reference LFSR: x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_pair(input logic [7:0] p1, input logic [7:0] p2,
                                             input logic [2:0] kk);
    logic [7:0] m;
    m = 8'((9'd1 << kk) - 9'd1);
    return {(p1 & ~m) | (p2 & m), (p2 & ~m) | (p1 & m)};
  endfunction

  initial begin
    logic [31:0] r;
    logic [2:0]  kk;

    // reset
    step();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_child1", child1, 8'h00);
    check("post_rst_count", xover_count, 16'h0);

    // forced cut 4
    parent1 = 8'h5A; parent2 = 8'hC3; force_en = 1'b1; force_cut = 3'd4;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("cut4_valid", out_valid, 1);
    check("cut4_child1", child1, 8'h53);
    check("cut4_child2", child2, 8'hCA);
    check("cut4_count", xover_count, 16'd1);

    // forced cut 0, accepted while the previous head pops
    force_cut = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("cut0_child1", child1, 8'h5A);
    check("cut0_child2", child2, 8'hC3);
    check("cut0_count", xover_count, 16'd1);
    step();
    @(negedge clk);
    check("cut0_drained", out_valid, 0);

    // backpressure and ordering, cut 0 so children equal parents
    out_ready = 1'b0; in_valid = 1'b1;
    parent1 = 8'h11; parent2 = 8'h22;
    step();
    parent1 = 8'h33; parent2 = 8'h44;
    step();
    parent1 = 8'h55; parent2 = 8'h66;
    @(negedge clk);
    check("bp_full_ready", in_ready, 0);
    check("bp_head_a", child1, 8'h11);
    step();
    @(negedge clk);
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_a1", child1, 8'h11);
    check("bp_hold_a2", child2, 8'h22);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_head_b", child1, 8'h33);
    check("bp_ready_again", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_head_c1", child1, 8'h55);
    check("bp_head_c2", child2, 8'h66);
    check("bp_c_valid", out_valid, 1);
    step();
    @(negedge clk);
    check("bp_empty", out_valid, 0);
    check("bp_count", xover_count, 16'd1);
    step();

    // streaming with forced cut 7
    force_cut = 3'd7;
    for (int i = 0; i < 100; i++) begin
      parent1 = 8'(i * 37 + 5); parent2 = 8'(i * 91 + 200); in_valid = 1'b1;
      @(negedge clk);
      check("stream_ready", in_ready, 1);
      if (i > 0) begin
        check("stream_valid", out_valid, 1);
        check("stream_child1", child1, prev1);
        check("stream_child2", child2, prev2);
      end
      prev1 = {parent1[7], parent2[6:0]};
      prev2 = {parent2[7], parent1[6:0]};
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last1", child1, prev1);
    check("stream_count", xover_count, 16'd101);
    step();

    // reset with the buffer full
    out_ready = 1'b0; force_cut = 3'd4; in_valid = 1'b1;
    parent1 = 8'h5A; parent2 = 8'hC3;
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_full_ready", in_ready, 0);
    check("mid_full_count", xover_count, 16'd103);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", in_ready, 0);
    #1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_valid", out_valid, 0);
    check("mid_post_child1", child1, 8'h00);
    check("mid_post_child2", child2, 8'h00);
    check("mid_post_count", xover_count, 16'd0);
    check("mid_post_ready", in_ready, 1);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_new_valid", out_valid, 1);
    check("mid_new_child1", child1, 8'h53);
    check("mid_new_child2", child2, 8'hCA);
    check("mid_new_count", xover_count, 16'd1);
    step();
    exp_count = 16'd1;

    // random draws against the reference LFSR
    force_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      parent1 = 8'($urandom); parent2 = 8'($urandom); in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        check("rand_child1", child1, prev1);
        check("rand_child2", child2, prev2);
      end
      r  = m_lfsr;
      kk = (r[7:0] < 8'd204) ? r[10:8] : 3'd0;
      {prev1, prev2} = model_pair(parent1, parent2, kk);
      if (kk != 3'd0) exp_count = exp_count + 16'd1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rand_last1", child1, prev1);
    check("rand_last2", child2, prev2);
    check("rand_count", xover_count, exp_count);
    step();

    // saturation
    reset = 1'b1;
    step();
    reset = 1'b0;
    force_en = 1'b1; force_cut = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    parent1 = 8'h0F; parent2 = 8'hF0;
    repeat (65534) step();
    @(negedge clk);
    check("sat_fffe", xover_count, 16'hFFFE);
    step();
    @(negedge clk);
    check("sat_ffff", xover_count, 16'hFFFF);
    repeat (5) step();
    @(negedge clk);
    check("sat_hold", xover_count, 16'hFFFF);
    check("sat_ready", in_ready, 1);
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
